// File: rtl/spi_ms_core.sv
// -----------------------------------------------------------------------------
// spi_ms_core
//   SPI master/slave peripheral with a byte-wide SFR bus for a host CPU.
//   Master mode generates SCK, drives MOSI and up to eight active-low
//   slave-select outputs. Slave mode follows an external SCK/MOSI/SSN
//   through a 2-FF synchronizer and drives MISO.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   sfraddr_w   write address: 0 SPCR, 1 SSCR, 2 SPBR, 3 SPDR
//   sfrwe       write strobe for spidata_i
//   spidata_i   SFR write data
//   sfraddr_r   read address: 0 SPCR, 1 SSCR, 2 SPBR, 3 RXBUF, 4 SSN,
//               5 SPSR, 6-7 read as zero
//   sfr_data_o  combinational read data
//   spssn_i     master slave-select request (active low)
//   spssn_o     registered slave-select outputs (active low)
//   mosi        master drives, slave samples
//   miso        selected slave drives, master samples
//   sck         master drives, slave samples
//   ssn         slave-select input (active low); in master mode a low
//               level is a mode fault
//
// SPCR: [6] SPE, [4] MSTR, [2] CPOL, [1] CPHA (other bits plain storage)
// SSCR: [0] SSOE
// SPBR: [2:0] n, SCK half-period = 2^n clk
// SPSR: [7] SPIF, [6] WCOL, [4] MODF, [0] BUSY (read-only)
// SSN : slave-select pattern captured when the last master transfer started
// -----------------------------------------------------------------------------
module spi_ms_core (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sfraddr_w,
    input  logic       sfrwe,
    input  logic [7:0] spidata_i,
    input  logic [2:0] sfraddr_r,
    output logic [7:0] sfr_data_o,
    input  logic [7:0] spssn_i,
    output logic [7:0] spssn_o,
    inout  wire        mosi,
    inout  wire        miso,
    inout  wire        sck,
    input  logic       ssn
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // SFRs and status
    logic [7:0] r_spcr;
    logic [7:0] r_sscr;
    logic [7:0] r_spbr;
    logic [7:0] r_spdr;
    logic [7:0] r_rxbuf;
    logic [7:0] r_ssncap;
    logic       r_spif;
    logic       r_wcol;
    logic       r_modf;
    logic       r_busy;

    // transfer engine
    logic [1:0] r_state;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic       r_obit;
    logic [2:0] r_bits;
    logic [3:0] r_edge;
    logic [7:0] r_hcnt;
    logic       r_sck;
    logic       r_cpol_x;
    logic       r_cpha_x;
    logic [2:0] r_div_x;
    logic       r_prev_ff;
    logic [7:0] r_spssn_o;

    // synchronizers for the slave-side inputs
    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_mosi_s1, r_mosi_s2;
    logic r_ssn_s1, r_ssn_s2, r_ssn_s3;

    logic       w_spe, w_mstr, w_cpol, w_cpha;
    logic       w_mst_en, w_slv_en;
    logic       w_modf_det;
    logic       w_start;
    logic [7:0] w_half_max;
    logic       w_m_tick, w_s_tick, w_tick;
    logic       w_sck_rise, w_sck_fall;
    logic       w_ssn_fall, w_ssn_rise;
    logic       w_lead;
    logic       w_in;
    logic       w_sample, w_shift;
    logic       w_spcr_wr;

    assign w_spe    = r_spcr[6];
    assign w_mstr   = r_spcr[4];
    assign w_cpol   = r_spcr[2];
    assign w_cpha   = r_spcr[1];
    assign w_mst_en = w_spe & w_mstr;
    assign w_slv_en = w_spe & ~w_mstr;

    assign w_modf_det = w_mst_en & ~r_ssn_s2;
    assign w_spcr_wr  = sfrwe && (sfraddr_w == 2'd0);

    // A new frame starts only on the FF -> non-FF transition of the request,
    // so holding spssn_i low never launches a second byte.
    assign w_start = (r_state == ST_IDLE) && w_mst_en && !w_modf_det &&
                     r_prev_ff && (spssn_i != 8'hFF);

    assign w_half_max = (8'd1 << r_div_x) - 8'd1;

    assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
    assign w_sck_fall = ~r_sck_s2 & r_sck_s3;
    assign w_ssn_fall = ~r_ssn_s2 & r_ssn_s3;
    assign w_ssn_rise = r_ssn_s2 & ~r_ssn_s3;

    assign w_m_tick = (r_state == ST_SHIFT) && (r_hcnt == w_half_max) &&
                      w_mst_en && !w_modf_det;
    assign w_s_tick = w_slv_en && r_busy && !r_ssn_s2 && (w_sck_rise || w_sck_fall);
    assign w_tick   = w_mstr ? w_m_tick : w_s_tick;

    // Leading edge = SCK leaving its idle level. The master knows this from
    // its own edge count; the slave infers it from the direction.
    assign w_lead = w_mstr ? ~r_edge[0] : (r_cpol_x ? w_sck_fall : w_sck_rise);
    assign w_in   = w_mstr ? miso : r_mosi_s2;

    // CPHA=0 samples on leading and shifts on trailing; CPHA=1 the reverse.
    assign w_sample = w_tick & (w_lead ^ r_cpha_x);
    assign w_shift  = w_tick & ~(w_lead ^ r_cpha_x);

    assign sck     = w_mst_en ? r_sck : 1'bz;
    assign mosi    = w_mst_en ? r_obit : 1'bz;
    // Drive only once the synchronized select has been low for two samples,
    // which is when the shift register has been reloaded.
    assign miso    = (w_slv_en && !r_ssn_s2 && !r_ssn_s3) ? r_obit : 1'bz;
    assign spssn_o = r_spssn_o;

    always_comb begin
        sfr_data_o = 8'h00;
        case (sfraddr_r)
            3'd0: sfr_data_o = r_spcr;
            3'd1: sfr_data_o = r_sscr;
            3'd2: sfr_data_o = r_spbr;
            3'd3: sfr_data_o = r_rxbuf;
            3'd4: sfr_data_o = r_ssncap;
            3'd5: sfr_data_o = {r_spif, r_wcol, 1'b0, r_modf, 3'b000, r_busy};
            default: sfr_data_o = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spcr    <= 8'h00;
            r_sscr    <= 8'h00;
            r_spbr    <= 8'h00;
            r_spdr    <= 8'h00;
            r_rxbuf   <= 8'h00;
            r_ssncap  <= 8'h00;
            r_spif    <= 1'b0;
            r_wcol    <= 1'b0;
            r_modf    <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
            r_tx      <= 8'h00;
            r_rx      <= 8'h00;
            r_obit    <= 1'b0;
            r_bits    <= 3'd0;
            r_edge    <= 4'd0;
            r_hcnt    <= 8'd0;
            r_sck     <= 1'b0;
            r_cpol_x  <= 1'b0;
            r_cpha_x  <= 1'b0;
            r_div_x   <= 3'd0;
            r_prev_ff <= 1'b0;
            r_spssn_o <= 8'hFF;
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_s3  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_ssn_s1  <= 1'b1;
            r_ssn_s2  <= 1'b1;
            r_ssn_s3  <= 1'b1;
        end else begin
            r_sck_s1  <= sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_ssn_s1  <= ssn;
            r_ssn_s2  <= r_ssn_s1;
            r_ssn_s3  <= r_ssn_s2;

            r_prev_ff <= (spssn_i == 8'hFF);
            r_spssn_o <= (r_sscr[0] && w_mst_en) ? spssn_i : 8'hFF;

            if (sfrwe) begin
                case (sfraddr_w)
                    2'd0: begin
                        r_spcr <= spidata_i;
                        r_modf <= 1'b0;
                    end
                    2'd1: r_sscr <= spidata_i;
                    2'd2: r_spbr <= spidata_i;
                    default: begin
                        if (r_busy) begin
                            r_wcol <= 1'b1;
                        end else begin
                            r_spdr <= spidata_i;
                            r_tx   <= spidata_i;
                            r_obit <= spidata_i[7];
                            r_spif <= 1'b0;
                            r_wcol <= 1'b0;
                        end
                    end
                endcase
            end

            // An SPCR write in the same cycle wins; the fault re-evaluates next cycle.
            if (w_modf_det && !w_spcr_wr) begin
                r_modf    <= 1'b1;
                r_spcr[4] <= 1'b0;
            end

            if (!w_spe || w_modf_det) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_hcnt  <= 8'd0;
                r_edge  <= 4'd0;
                r_bits  <= 3'd0;
                r_sck   <= w_cpol;
            end else if (w_mstr) begin
                case (r_state)
                    ST_IDLE: begin
                        r_sck <= w_cpol;
                        if (w_start) begin
                            r_cpol_x <= w_cpol;
                            r_cpha_x <= w_cpha;
                            r_div_x  <= r_spbr[2:0];
                            // CPHA=0 presents the MSB before the first edge,
                            // so the next bit to shift out is bit 6.
                            r_tx     <= w_cpha ? r_spdr : {r_spdr[6:0], 1'b0};
                            r_obit   <= r_spdr[7];
                            r_busy   <= 1'b1;
                            r_hcnt   <= 8'd0;
                            r_edge   <= 4'd0;
                            r_bits   <= 3'd0;
                            r_ssncap <= spssn_i;
                            r_state  <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (w_m_tick) begin
                            r_hcnt <= 8'd0;
                            r_sck  <= ~r_sck;
                            r_edge <= r_edge + 4'd1;
                            if (r_edge == 4'd15) begin
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_hcnt <= r_hcnt + 8'd1;
                        end
                    end
                    ST_DONE: begin
                        r_rxbuf <= r_rx;
                        r_spif  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else begin
                r_state <= ST_IDLE;
                r_sck   <= w_cpol;
                if (w_ssn_fall) begin
                    r_cpol_x <= w_cpol;
                    r_cpha_x <= w_cpha;
                    r_tx     <= w_cpha ? r_spdr : {r_spdr[6:0], 1'b0};
                    r_obit   <= r_spdr[7];
                    r_bits   <= 3'd0;
                    r_busy   <= 1'b1;
                end else if (w_ssn_rise) begin
                    // partial byte is dropped; RXBUF and SPIF stay as they were
                    r_busy <= 1'b0;
                    r_bits <= 3'd0;
                end
            end

            if (w_sample) begin
                r_rx   <= {r_rx[6:0], w_in};
                r_bits <= r_bits + 3'd1;
                if (!w_mstr && (r_bits == 3'd7)) begin
                    r_rxbuf <= {r_rx[6:0], w_in};
                    r_spif  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            end

            if (w_shift) begin
                r_obit <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_ms_core.sv
module tb_spi_ms_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] m_waddr = 2'd0, s_waddr = 2'd0;
    logic       m_we = 1'b0, s_we = 1'b0;
    logic [7:0] m_wdata = 8'h00, s_wdata = 8'h00;
    logic [2:0] m_raddr = 3'd0, s_raddr = 3'd0;
    logic [7:0] m_rdata, s_rdata;
    logic [7:0] m_spssn_i = 8'hFF, s_spssn_i = 8'hFF;
    logic [7:0] m_spssn_o, s_spssn_o;
    logic       m_ssn = 1'b1;
    wire        mosi, miso, sck;

    // Undriven shared lines read as 1, so a released line is visible.
    pullup pu_mosi (mosi);
    pullup pu_miso (miso);
    pullup pu_sck  (sck);

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_m_q[$];
    logic [7:0] exp_s_q[$];

    always #5 clk = ~clk;

    spi_ms_core u_mst (
        .clk(clk), .rst(rst),
        .sfraddr_w(m_waddr), .sfrwe(m_we), .spidata_i(m_wdata),
        .sfraddr_r(m_raddr), .sfr_data_o(m_rdata),
        .spssn_i(m_spssn_i), .spssn_o(m_spssn_o),
        .mosi(mosi), .miso(miso), .sck(sck), .ssn(m_ssn)
    );

    spi_ms_core u_slv (
        .clk(clk), .rst(rst),
        .sfraddr_w(s_waddr), .sfrwe(s_we), .spidata_i(s_wdata),
        .sfraddr_r(s_raddr), .sfr_data_o(s_rdata),
        .spssn_i(s_spssn_i), .spssn_o(s_spssn_o),
        .mosi(mosi), .miso(miso), .sck(sck), .ssn(m_spssn_o[0])
    );

    task automatic wr(input bit slv, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        if (slv) begin s_we = 1'b1; s_waddr = a; s_wdata = d; end
        else     begin m_we = 1'b1; m_waddr = a; m_wdata = d; end
        @(negedge clk);
        s_we = 1'b0;
        m_we = 1'b0;
    endtask

    task automatic rd(input bit slv, input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        if (slv) s_raddr = a; else m_raddr = a;
        #1;
        v = slv ? s_rdata : m_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(1'b0, 3'(a), v);
            checks++;
            if (v !== 8'h00) begin failures++; $display("FAIL reset_rd_mst addr=%0d got=%h exp=00", a, v); end
            rd(1'b1, 3'(a), v);
            checks++;
            if (v !== 8'h00) begin failures++; $display("FAIL reset_rd_slv addr=%0d got=%h exp=00", a, v); end
        end
        checks++;
        if (m_spssn_o !== 8'hFF) begin failures++; $display("FAIL reset_spssn_mst got=%h exp=FF", m_spssn_o); end
        checks++;
        if (s_spssn_o !== 8'hFF) begin failures++; $display("FAIL reset_spssn_slv got=%h exp=FF", s_spssn_o); end
        checks++;
        if ({sck, mosi, miso} !== 3'b111) begin failures++; $display("FAIL reset_lines_z got=%b exp=111", {sck, mosi, miso}); end
    endtask

    // One complete byte exchange master <-> slave with scoreboard checks.
    task automatic xfer(input logic [7:0] mcr, input logic [7:0] scr,
                        input logic [7:0] mb, input logic [7:0] sb, input bit wcol_inj);
        logic [7:0] v, spsr, exp;
        logic       prev_sck;
        int         tog, first, last;
        bit         done;
        wr(1'b1, 2'd0, scr);
        wr(1'b1, 2'd3, sb);
        wr(1'b0, 2'd0, mcr);
        wr(1'b0, 2'd1, 8'h01);
        wr(1'b0, 2'd2, 8'h03);
        wr(1'b0, 2'd3, mb);
        exp_s_q.push_back(mb);
        exp_m_q.push_back(sb);
        tog = 0; first = -1; last = -1; done = 1'b0;
        prev_sck = sck;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            m_spssn_i = 8'hFE;
            m_we = (wcol_inj && cyc == 30);
            m_waddr = 2'd3;
            m_wdata = ~mb;
            m_raddr = 3'd5;
            #1;
            spsr = m_rdata;
            if (sck !== prev_sck) begin
                tog++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            prev_sck = sck;
            if (cyc == 4) begin
                checks++;
                if (m_spssn_o !== 8'hFE) begin failures++; $display("FAIL xfer_spssn_o got=%h exp=FE", m_spssn_o); end
            end
            if (wcol_inj && cyc == 40) begin
                checks++;
                if (spsr[6] !== 1'b1) begin failures++; $display("FAIL wcol_set got=%b exp=1", spsr[6]); end
            end
            if (spsr[7]) done = 1'b1;
        end
        m_we = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL xfer_timeout mcr=%h got=no_spif exp=spif", mcr); end
        m_spssn_i = 8'hFF;
        repeat (12) @(negedge clk);
        checks++;
        if (tog != 16) begin failures++; $display("FAIL sck_edges mcr=%h got=%0d exp=16", mcr, tog); end
        checks++;
        if (last - first != 120) begin failures++; $display("FAIL sck_span mcr=%h got=%0d exp=120", mcr, last - first); end
        checks++;
        if (sck !== mcr[2]) begin failures++; $display("FAIL sck_idle mcr=%h got=%b exp=%b", mcr, sck, mcr[2]); end
        rd(1'b0, 3'd3, v);
        exp = exp_m_q.pop_front();
        checks++;
        if (v !== exp) begin failures++; $display("FAIL mst_rxbuf mcr=%h got=%h exp=%h", mcr, v, exp); end
        rd(1'b1, 3'd3, v);
        exp = exp_s_q.pop_front();
        checks++;
        if (v !== exp) begin failures++; $display("FAIL slv_rxbuf scr=%h got=%h exp=%h", scr, v, exp); end
        rd(1'b0, 3'd5, v);
        exp = wcol_inj ? 8'hC0 : 8'h80;
        checks++;
        if (v !== exp) begin failures++; $display("FAIL mst_spsr got=%h exp=%h", v, exp); end
        rd(1'b1, 3'd5, v);
        checks++;
        if (v !== 8'h80) begin failures++; $display("FAIL slv_spsr got=%h exp=80", v); end
    endtask

    task automatic test_basic();
        xfer(8'h50, 8'h40, 8'hA5, 8'h3C, 1'b0);
    endtask

    task automatic test_modes();
        for (int i = 1; i < 4; i++) begin
            xfer(8'h50 | 8'(i << 1), 8'h40 | 8'(i << 1),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        end
    endtask

    task automatic test_wcol();
        logic [7:0] v;
        xfer(8'h50, 8'h40, 8'h96, 8'h69, 1'b1);
        wr(1'b0, 2'd3, 8'h11);
        rd(1'b0, 3'd5, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL wcol_clear got=%h exp=00", v); end
    endtask

    task automatic test_slave_abort();
        logic [7:0] v, prev;
        bit done;
        rd(1'b1, 3'd3, prev);
        wr(1'b1, 2'd0, 8'h40);
        wr(1'b1, 2'd3, 8'h00);
        wr(1'b0, 2'd0, 8'h50);
        wr(1'b0, 2'd1, 8'h01);
        wr(1'b0, 2'd2, 8'h03);
        wr(1'b0, 2'd3, 8'h5A);
        done = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            m_spssn_i = 8'hFE;
            // Dropping SSOE mid-byte raises the slave's select after 4 samples.
            m_we = (cyc == 60);
            m_waddr = 2'd1;
            m_wdata = 8'h00;
            m_raddr = 3'd5;
            #1;
            if (m_rdata[7]) done = 1'b1;
        end
        m_we = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL abort_timeout got=no_spif exp=spif"); end
        m_spssn_i = 8'hFF;
        repeat (4) @(negedge clk);
        rd(1'b1, 3'd5, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL abort_slv_spsr got=%h exp=00", v); end
        rd(1'b1, 3'd3, v);
        checks++;
        if (v !== prev) begin failures++; $display("FAIL abort_slv_rxbuf got=%h exp=%h", v, prev); end
        checks++;
        if (miso !== 1'b1) begin failures++; $display("FAIL abort_miso_z got=%b exp=1(released)", miso); end
        xfer(8'h50, 8'h40, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic test_modf_and_reset();
        logic [7:0] v;
        wr(1'b0, 2'd0, 8'h50);
        wr(1'b0, 2'd1, 8'h01);
        wr(1'b0, 2'd3, 8'h00);
        @(negedge clk);
        m_ssn = 1'b0;
        repeat (6) @(negedge clk);
        rd(1'b0, 3'd5, v);
        checks++;
        if (v !== 8'h10) begin failures++; $display("FAIL modf_spsr got=%h exp=10", v); end
        rd(1'b0, 3'd0, v);
        checks++;
        if (v !== 8'h40) begin failures++; $display("FAIL modf_spcr got=%h exp=40", v); end
        checks++;
        if ({sck, mosi} !== 2'b11) begin failures++; $display("FAIL modf_lines_z got=%b exp=11", {sck, mosi}); end
        checks++;
        if (m_spssn_o !== 8'hFF) begin failures++; $display("FAIL modf_spssn got=%h exp=FF", m_spssn_o); end
        m_ssn = 1'b1;
        repeat (4) @(negedge clk);
        wr(1'b0, 2'd0, 8'h50);
        rd(1'b0, 3'd5, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL modf_clear got=%h exp=00", v); end

        wr(1'b1, 2'd0, 8'h40);
        wr(1'b1, 2'd3, 8'hC3);
        wr(1'b0, 2'd3, 8'hA5);
        @(negedge clk);
        m_spssn_i = 8'hFE;
        repeat (40) @(negedge clk);
        rd(1'b0, 3'd5, v);
        checks++;
        if (v !== 8'h01) begin failures++; $display("FAIL midxfer_busy got=%h exp=01", v); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_spssn_i = 8'hFF;
        for (int a = 0; a < 8; a++) begin
            rd(1'b0, 3'(a), v);
            checks++;
            if (v !== 8'h00) begin failures++; $display("FAIL rst_mid_mst addr=%0d got=%h exp=00", a, v); end
            rd(1'b1, 3'(a), v);
            checks++;
            if (v !== 8'h00) begin failures++; $display("FAIL rst_mid_slv addr=%0d got=%h exp=00", a, v); end
        end
        checks++;
        if (m_spssn_o !== 8'hFF) begin failures++; $display("FAIL rst_mid_spssn got=%h exp=FF", m_spssn_o); end
        checks++;
        if ({sck, mosi, miso} !== 3'b111) begin failures++; $display("FAIL rst_mid_lines_z got=%b exp=111", {sck, mosi, miso}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_wcol();
        test_slave_abort();
        test_modf_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
